// File: rtl/ling_addsub_serial_pkg.sv
// Shared definitions for the nibble-serial Ling adder/subtractor.
package ling_addsub_serial_pkg;

  // Width of the slice handled by the lookahead generator each cycle.
  localparam int unsigned NIB = 4;

  // Transaction state of the serial datapath.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ling_addsub_serial_lclg.sv
// 4-bit Ling carry lookahead generator.
// Ling pseudo-carries h[i+1] = g[i] | c[i] are formed in flattened two-level
// form; true carries are recovered as c[i+1] = p[i] & h[i+1].
module lclg_4 (
  input  logic [3:0] g,
  input  logic [3:0] p,
  input  logic       cin,
  output logic [4:0] c
);

  logic [4:1] h;

  // Pseudo-carries and true carries for the 4-bit slice.
  always_comb begin
    h[1] = g[0] | cin;
    h[2] = g[1] | g[0] | (p[0] & cin);
    h[3] = g[2] | g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    h[4] = g[3] | g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & cin);
    c[0] = cin;
    c[1] = p[0] & h[1];
    c[2] = p[1] & h[2];
    c[3] = p[2] & h[3];
    c[4] = p[3] & h[4];
  end

endmodule

// File: rtl/ling_addsub_serial.sv
// Nibble-serial adder/subtractor built around a single Ling lookahead slice.
// One nibble is resolved per cycle; the carry is registered between nibbles.
module ling_addsub_serial
  import ling_addsub_serial_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int unsigned NNIB = W / NIB;
  localparam int unsigned CW   = (NNIB > 1) ? $clog2(NNIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NNIB - 1);

  state_t         state;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [W-1:0]   res;
  logic           carry;
  logic [CW-1:0]  cnt;
  logic           cout_q;
  logic           ovf_q;
  logic           in_ready_q;
  logic           out_valid_q;

  logic [NIB-1:0] a_nib;
  logic [NIB-1:0] b_nib;
  logic [NIB-1:0] g;
  logic [NIB-1:0] p;
  logic [NIB-1:0] s;
  logic [NIB:0]   c;

  // Select the active nibble and form generate/propagate and sum bits.
  always_comb begin
    a_nib = a_q[cnt*NIB +: NIB];
    b_nib = b_q[cnt*NIB +: NIB];
    g     = a_nib & b_nib;
    p     = a_nib | b_nib;
    s     = a_nib ^ b_nib ^ c[NIB-1:0];
  end

  lclg_4 u_lclg (
    .g   (g),
    .p   (p),
    .cin (carry),
    .c   (c)
  );

  // Control FSM and datapath registers; handshake outputs are registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      carry       <= 1'b0;
      res         <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q        <= a;
            b_q        <= sub ? ~b : b;
            carry      <= sub;
            cnt        <= '0;
            state      <= RUN;
            in_ready_q <= 1'b0;
          end
        end
        RUN: begin
          res[cnt*NIB +: NIB] <= s;
          carry               <= c[NIB];
          cnt                 <= cnt + 1'b1;
          if (cnt == LAST) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
            cout_q      <= c[NIB];
            ovf_q       <= c[NIB] ^ c[NIB-1];
          end
        end
        DONE: begin
          if (out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = res;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_ling_addsub_serial.sv
// Directed and randomised checks for the nibble-serial adder/subtractor.
module tb_ling_addsub_serial;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;

  int checks;
  int failures;

  ling_addsub_serial #(.W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one operand set in IDLE for a single edge.
  task automatic start_op(input logic [31:0] ta, input logic [31:0] tb, input logic ts);
    a = ta; b = tb; sub = ts; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Count edges until out_valid rises, bounded at 20.
  task automatic wait_done(output int edges);
    edges = 0;
    while (out_valid !== 1'b1 && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  // Complete the output handshake.
  task automatic take_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; a = 32'hDEADBEEF; b = 32'h1; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (sum !== 32'h0) begin failures++; $display("FAIL reset_sum got=%h exp=00000000", sum); end
    checks++; if ({cout, ovf} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b exp=00", {cout, ovf}); end
    in_valid = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_idle got=%b exp=1", in_ready); end
  endtask

  task automatic test_ripple();
    int e;
    start_op(32'hFFFFFFFF, 32'h00000001, 1'b0);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL ripple_busy got=%b exp=0", in_ready); end
    wait_done(e);
    checks++; if (e !== 8) begin failures++; $display("FAIL ripple_latency got=%0d exp=8", e); end
    checks++; if (sum !== 32'h00000000) begin failures++; $display("FAIL ripple_sum got=%h exp=00000000", sum); end
    checks++; if ({cout, ovf} !== 2'b10) begin failures++; $display("FAIL ripple_flags got=%b exp=10", {cout, ovf}); end
    take_result();
  endtask

  task automatic test_overflow();
    int e;
    start_op(32'h80000000, 32'h00000001, 1'b1);
    wait_done(e);
    checks++; if (e !== 8) begin failures++; $display("FAIL ovf_latency got=%0d exp=8", e); end
    checks++; if (sum !== 32'h7FFFFFFF) begin failures++; $display("FAIL ovf_sum got=%h exp=7fffffff", sum); end
    checks++; if ({cout, ovf} !== 2'b11) begin failures++; $display("FAIL ovf_flags got=%b exp=11", {cout, ovf}); end
    take_result();
  endtask

  // Extra directed boundary vectors: {a, b, sub, sum, cout, ovf}.
  task automatic test_vectors();
    int e;
    logic [31:0] va [4] = '{32'h00000000, 32'h00000005, 32'h7FFFFFFF, 32'hFFFFFFFF};
    logic [31:0] vb [4] = '{32'h00000000, 32'h00000007, 32'h00000001, 32'hFFFFFFFF};
    logic        vs [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] xs [4] = '{32'h00000000, 32'hFFFFFFFE, 32'h80000000, 32'hFFFFFFFE};
    logic [1:0]  xf [4] = '{2'b10, 2'b00, 2'b01, 2'b10};
    for (int i = 0; i < 4; i++) begin
      start_op(va[i], vb[i], vs[i]);
      wait_done(e);
      checks++; if (sum !== xs[i]) begin failures++; $display("FAIL vec%0d_sum got=%h exp=%h", i, sum, xs[i]); end
      checks++; if ({cout, ovf} !== xf[i]) begin failures++; $display("FAIL vec%0d_flags got=%b exp=%b", i, {cout, ovf}, xf[i]); end
      take_result();
    end
  endtask

  task automatic test_backpressure();
    int e;
    start_op(32'h12345678, 32'h11111111, 1'b0);
    wait_done(e);
    for (int i = 0; i < 5; i++) begin
      checks++; if (sum !== 32'h23456789) begin failures++; $display("FAIL bp_sum%0d got=%h exp=23456789", i, sum); end
      checks++; if ({out_valid, in_ready, cout, ovf} !== 4'b1000) begin
        failures++; $display("FAIL bp_ctl%0d got=%b exp=1000", i, {out_valid, in_ready, cout, ovf});
      end
      @(posedge clk); #1;
    end
    take_result();
    checks++; if ({in_ready, out_valid} !== 2'b10) begin failures++; $display("FAIL bp_idle got=%b exp=10", {in_ready, out_valid}); end
  endtask

  task automatic test_reset_mid_run();
    int seen;
    start_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++; if ({in_ready, out_valid} !== 2'b10) begin failures++; $display("FAIL rstrun_ctl got=%b exp=10", {in_ready, out_valid}); end
    checks++; if (sum !== 32'h0) begin failures++; $display("FAIL rstrun_sum got=%h exp=00000000", sum); end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL rstrun_late_valid got=%0d exp=0", seen); end
  endtask

  task automatic test_back_to_back();
    int e;
    a = 32'h00000010; b = 32'h00000020; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 8 && out_valid !== 1'b1; i++) begin
      a = 32'h00000100; b = 32'h00000001; sub = 1'b1;
      if (i % 2 == 0) begin a = 32'hA5A5A5A5; b = 32'h5A5A5A5A; sub = 1'b0; end
      @(posedge clk); #1;
    end
    a = 32'h00000100; b = 32'h00000001; sub = 1'b1;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_first_valid got=%b exp=1", out_valid); end
    checks++; if (sum !== 32'h00000030) begin failures++; $display("FAIL b2b_first_sum got=%h exp=00000030", sum); end
    @(posedge clk); #1;
    checks++; if ({in_ready, out_valid} !== 2'b01) begin failures++; $display("FAIL b2b_hold got=%b exp=01", {in_ready, out_valid}); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_idle got=%b exp=1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_second_accept got=%b exp=0", in_ready); end
    wait_done(e);
    checks++; if (e !== 8) begin failures++; $display("FAIL b2b_latency got=%0d exp=8", e); end
    checks++; if (sum !== 32'h000000FF) begin failures++; $display("FAIL b2b_second_sum got=%h exp=000000ff", sum); end
    checks++; if ({cout, ovf} !== 2'b10) begin failures++; $display("FAIL b2b_second_flags got=%b exp=10", {cout, ovf}); end
    take_result();
  endtask

  task automatic test_random();
    int e;
    logic [31:0] ra, rb, bb, rs;
    logic        rsub, rc, rv;
    for (int n = 0; n < 3000; n++) begin
      ra = $urandom; rb = $urandom; rsub = 1'($urandom_range(0, 1));
      if (n % 7 == 0) ra = 32'h80000000;
      if (n % 11 == 0) rb = 32'hFFFFFFFF;
      bb = rsub ? ~rb : rb;
      {rc, rs} = {1'b0, ra} + {1'b0, bb} + {32'h0, rsub};
      rv = (ra[31] == bb[31]) && (rs[31] != ra[31]);
      start_op(ra, rb, rsub);
      wait_done(e);
      checks++; if ({sum, cout, ovf} !== {rs, rc, rv} || e !== 8) begin
        failures++;
        $display("FAIL rand%0d a=%h b=%h sub=%b got=%h/%b/%b/%0d exp=%h/%b/%b/8", n, ra, rb, rsub, sum, cout, ovf, e, rs, rc, rv);
      end
      take_result();
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0; rst_n = 1'b0;
    test_reset();
    test_ripple();
    test_overflow();
    test_vectors();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
